// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder:
// digit width, largest legal digit, FSM states and a digit validity check.
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcdadd.sv
// One-digit BCD adder, purely combinational.
// Ports: cin, a[3:0], b[3:0] in; sum[3:0] (0..9 for legal inputs), cout out.
module bcdadd
    import bcd_pkg::*;
(
    input  logic               cin,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    logic [DIGIT_W:0]   w_bin;
    logic [DIGIT_W-1:0] w_fix;

    assign w_bin = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};

    // Binary sum above 9 wraps to the next decade: add 6 and emit a carry.
    assign cout  = w_bin > {1'b0, BCD_MAX};
    assign w_fix = w_bin[DIGIT_W-1:0] + 4'd6;
    assign sum   = cout ? w_fix : w_bin[DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one bcdadd reused per digit, LSD first.
// Ports: clk, rst (async high), start, cin, a/b (packed BCD) in;
//        busy, done (1-cycle pulse), sum, cout, err (held results) out.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cin,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                      cout,
    output logic                      err
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]      r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_err;

    logic               w_accept;
    logic               w_last;
    logic [DIGIT_W-1:0] w_da;
    logic [DIGIT_W-1:0] w_db;
    logic [DIGIT_W-1:0] w_ds;
    logic               w_dc;

    function automatic logic any_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | !is_bcd(v[DIGIT_W*i +: DIGIT_W]);
        return bad;
    endfunction

    assign w_last = (r_idx == IW'(DIGITS - 1));
    assign w_da   = r_a[DIGIT_W*r_idx +: DIGIT_W];
    assign w_db   = r_b[DIGIT_W*r_idx +: DIGIT_W];

    bcdadd u_bcdadd (
        .cin  (r_carry),
        .a    (w_da),
        .b    (w_db),
        .sum  (w_ds),
        .cout (w_dc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last)
                    w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
            r_err   <= any_bad(a) | any_bad(b);
        end else if (r_state == RUN) begin
            r_sum[DIGIT_W*r_idx +: DIGIT_W] <= w_ds;
            r_carry <= w_dc;
            // Park idx at 0 after the last digit so it never points past r_a.
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_last)
                r_cout <= w_dc;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule
